// File: rtl/sm_mem_arb_pkg.sv
// Shared types for the I/D memory arbiter: port owner encoding and the
// per-stage record of the in-flight read tracker.
package sm_mem_arb_pkg;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   typedef struct packed {
      logic   vld;
      owner_e own;
   } stage_t;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

   function automatic logic lat_legal(input int lat);
      return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
   endfunction

endpackage

// File: rtl/sm_arb_resp_pipe.sv
// Owner/valid shift register: one stage per cycle of memory read latency, so the
// last stage lines up with the cycle the memory presents read data.
module sm_arb_resp_pipe
   import sm_mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_vld,
   input  owner_e push_own,
   output logic   pop_vld,
   output owner_e pop_own,
   output logic   busy
);

   if (!lat_legal(MEM_LAT)) begin : g_bad_lat
      $error("sm_arb_resp_pipe: MEM_LAT must be in 1..4");
   end

   stage_t [MEM_LAT-1:0] stg;

   // NOTE: non-blocking assignments let every stage sample its neighbour's old value, which is what makes this a shift register rather than a broadcast.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only a few flops, and resetting them is what drops in-flight reads, so the whole array is reset.
         stg <= '0;
      end else begin
         stg[0] <= '{vld: push_vld, own: push_own};
         for (int k = 1; k < MEM_LAT; k++) begin
            stg[k] <= stg[k-1];
         end
      end
   end

   assign pop_vld = stg[MEM_LAT-1].vld;
   assign pop_own = stg[MEM_LAT-1].own;

   // NOTE: default assignment first so no path leaves busy unassigned (no latch).
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < MEM_LAT; k++) begin
         busy = busy | stg[k].vld;
      end
   end

endmodule

// File: rtl/sm_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// Define SM_MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I.
module sm_mem_arbiter
   import sm_mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);

   logic          sel_d;
   logic          pop_vld;
   owner_e        pop_own;
   logic          pipe_busy;
   logic          rsp_vld;
   logic [DW-1:0] i_rdata_q;
   logic [DW-1:0] d_rdata_q;

`ifdef SM_MEM_ARB_RR_EN
   owner_e last_own;

   // On contention the port that did not win last time goes first.
   always_comb begin
      sel_d = d_req & (~i_req | (last_own == OWN_I));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_own <= OWN_I;
      end else if (i_gnt | d_gnt) begin
         last_own <= d_gnt ? OWN_D : OWN_I;
      end
   end
`else
   assign sel_d = d_req;
`endif

   assign d_gnt = ~rst & sel_d;
   assign i_gnt = ~rst & i_req & ~sel_d;
   assign m_req = i_gnt | d_gnt;
   assign m_we  = d_gnt & d_we;

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      if (d_gnt) begin
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (i_gnt) begin
         m_addr  = i_addr;
      end
   end

   sm_arb_resp_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_resp_pipe (
      .clk      (clk),
      .rst      (rst),
      .push_vld (i_gnt | (d_gnt & ~d_we)),
      .push_own (d_gnt ? OWN_D : OWN_I),
      .pop_vld  (pop_vld),
      .pop_own  (pop_own),
      .busy     (pipe_busy)
   );

   // Reset wins over a response arriving in the same cycle.
   assign rsp_vld  = ~rst & pop_vld;
   assign i_rvalid = rsp_vld & (pop_own == OWN_I);
   assign d_rvalid = rsp_vld & (pop_own == OWN_D);
   assign busy     = ~rst & pipe_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (i_rvalid) i_rdata_q <= m_rdata;
         if (d_rvalid) d_rdata_q <= m_rdata;
      end
   end

   // Owner sees memory data the cycle it arrives; the other port keeps its last word.
   assign i_rdata = i_rvalid ? m_rdata : i_rdata_q;
   assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Bench for sm_mem_arbiter: two instances (MEM_LAT 1 and 3) share stimulus and are
// checked cycle by cycle against a queue-based transaction model.
module tb_sm_mem_arbiter;

   localparam int OBS_W = 204;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;

   logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_req1, m_we1, busy1;
   logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
   logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_req3, m_we3, busy3;
   logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;

   always #5 clk = ~clk;

   sm_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt1),
      .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .m_req(m_req1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
      .busy(busy1)
   );

   sm_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt3),
      .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .m_req(m_req3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
      .busy(busy3)
   );

   // Memory devices: fixed-latency RAMs; junk on the read bus when no read is due.
   logic        init_mem;
   logic [31:0] seed_val [16];
   logic [31:0] ram1 [16];
   logic [31:0] ram3 [16];
   logic [31:0] dl1;
   logic [31:0] dl3 [3];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int k = 0; k < 16; k++) ram1[k] <= seed_val[k];
      end else if (m_req1 && m_we1) begin
         ram1[m_addr1[3:0]] <= m_wdata1;
      end
      dl1 <= (m_req1 && !m_we1) ? ram1[m_addr1[3:0]] : $urandom;
   end
   assign m_rdata1 = dl1;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int k = 0; k < 16; k++) ram3[k] <= seed_val[k];
      end else if (m_req3 && m_we3) begin
         ram3[m_addr3[3:0]] <= m_wdata3;
      end
      dl3[0] <= (m_req3 && !m_we3) ? ram3[m_addr3[3:0]] : $urandom;
      dl3[1] <= dl3[0];
      dl3[2] <= dl3[1];
   end
   assign m_rdata3 = dl3[2];

   // Transaction-level reference model
   typedef struct {
      int          due;
      bit          own_d;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   rsp_t        q1[$];
   rsp_t        q3[$];
   logic [31:0] iq[$];
   dreq_t       dq[$];
   logic [31:0] ref_mem [16];
   logic [31:0] hold_i1, hold_d1, hold_i3, hold_d3;
   bit          last_d;
   int          cyc;
   bit          e_gi, e_gd;
   logic [OBS_W-1:0] exp_v;

   int nvec = 0;
   int nerr = 0;

   function automatic logic [66:0] resp_exp(input rsp_t q[$], input logic [31:0] hi,
                                            input logic [31:0] hd);
      logic        vi, vd;
      logic [31:0] di, dd;
      vi = 1'b0; vd = 1'b0; di = hi; dd = hd;
      if (!rst && q.size() > 0 && q[0].due == cyc) begin
         if (q[0].own_d) begin vd = 1'b1; dd = q[0].data; end
         else            begin vi = 1'b1; di = q[0].data; end
      end
      return {vi, vd, di, dd, (!rst && q.size() > 0)};
   endfunction

   function automatic logic [OBS_W-1:0] observe();
      return {i_gnt1, d_gnt1, m_req1, m_we1, m_addr1, (m_req1 && !d_gnt1) ? 32'h0 : m_wdata1,
              i_rvalid1, d_rvalid1, i_rdata1, d_rdata1, busy1,
              i_rvalid3, d_rvalid3, i_rdata3, d_rdata3, busy3, i_gnt3, d_gnt3};
   endfunction

   task automatic drive();
      i_req  = (iq.size() != 0);
      i_addr = i_req ? iq[0] : $urandom;
      if (dq.size() != 0) begin
         d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
      end else begin
         d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
   endtask

   task automatic settle();
      bit pref_d;
      @(negedge clk);
`ifdef SM_MEM_ARB_RR_EN
      pref_d = !last_d;
`else
      pref_d = 1'b1;
`endif
      e_gd  = !rst && d_req && (!i_req || pref_d);
      e_gi  = !rst && i_req && !e_gd;
      exp_v = {e_gi, e_gd, e_gi | e_gd, e_gd & d_we,
               e_gd ? d_addr : (e_gi ? i_addr : 32'h0), e_gd ? d_wdata : 32'h0,
               resp_exp(q1, hold_i1, hold_d1), resp_exp(q3, hold_i3, hold_d3), e_gi, e_gd};
   endtask

   task automatic commit();
      rsp_t       r;
      logic [3:0] a;
      @(posedge clk);
      if (rst) begin
         q1.delete(); q3.delete();
         hold_i1 = '0; hold_d1 = '0; hold_i3 = '0; hold_d3 = '0;
         last_d  = 1'b0;
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin
            if (q1[0].own_d) hold_d1 = q1[0].data; else hold_i1 = q1[0].data;
            void'(q1.pop_front());
         end
         if (q3.size() > 0 && q3[0].due == cyc) begin
            if (q3[0].own_d) hold_d3 = q3[0].data; else hold_i3 = q3[0].data;
            void'(q3.pop_front());
         end
         a = e_gd ? d_addr[3:0] : i_addr[3:0];
         if (e_gd && d_we) begin
            ref_mem[a] = d_wdata;
         end else if (e_gd || e_gi) begin
            r.own_d = e_gd; r.data = ref_mem[a];
            r.due = cyc + 1; q1.push_back(r);
            r.due = cyc + 3; q3.push_back(r);
         end
         if (e_gd || e_gi) last_d = e_gd;
         if (e_gi) void'(iq.pop_front());
         if (e_gd) void'(dq.pop_front());
      end
      cyc++;
      #1;
   endtask

   function automatic dreq_t mk_d(input bit we, input logic [31:0] addr, input logic [31:0] wd);
      dreq_t t;
      t.we = we; t.addr = addr; t.wdata = wd;
      return t;
   endfunction

   task automatic test_reset();
      for (int k = 0; k < 3; k++) dq.push_back(mk_d(1'($urandom), 32'(k + 9), $urandom));
      iq = '{32'd3, 32'd11};
      rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k == 3) rst = 1'b0;
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL reset cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         if (k < 3) begin
            nvec++;
            if ({i_gnt1, d_gnt1, m_req1, busy1, i_rvalid1, d_rvalid1, i_rdata1, d_rdata1} !== 38'h0) begin
               nerr++; $display("FAIL reset_state cyc%0d gnt %b%b mreq %b busy %b rdata %h/%h exp all 0",
                                k, i_gnt1, d_gnt1, m_req1, busy1, i_rdata1, d_rdata1);
            end
         end
         commit();
      end
   endtask

   task automatic test_fetch_burst();
      iq = '{32'd0, 32'd1, 32'd2};
      for (int k = 0; k < 6; k++) begin
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL fetch_burst cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         if (k >= 1 && k <= 3) begin
            nvec++;
            if ({i_rvalid1, d_rvalid1, i_rdata1} !== {2'b10, ref_mem[k-1]}) begin
               nerr++; $display("FAIL fetch_data cyc%0d got v%b%b %h exp v10 %h",
                                k, i_rvalid1, d_rvalid1, i_rdata1, ref_mem[k-1]);
            end
         end
         commit();
      end
   endtask

   task automatic test_priority();
      iq = '{32'd4};
      dq.push_back(mk_d(1'b0, 32'd8, $urandom));
      for (int k = 0; k < 6; k++) begin
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL priority cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         if (k == 0) begin
            nvec++;
            if ({d_gnt1, i_gnt1} !== 2'b10) begin
               nerr++; $display("FAIL priority_gnt got d%b i%b exp d1 i0", d_gnt1, i_gnt1);
            end
         end
         if (k == 1) begin
            nvec++;
            if ({d_rvalid1, d_rdata1, i_gnt1} !== {1'b1, ref_mem[8], 1'b1}) begin
               nerr++; $display("FAIL priority_dload got v%b %h ig%b exp v1 %h ig1",
                                d_rvalid1, d_rdata1, i_gnt1, ref_mem[8]);
            end
         end
         commit();
      end
   endtask

   task automatic test_write_then_fetch();
      dq.push_back(mk_d(1'b1, 32'd5, 32'hDEADBEEF));
      for (int k = 0; k < 7; k++) begin
         if (k == 1) iq = '{32'd5};
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL write_fetch cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         nvec++;
         if (d_rvalid1 || d_rvalid3) begin
            nerr++; $display("FAIL write_no_drvalid cyc%0d got %b%b exp 00", k, d_rvalid1, d_rvalid3);
         end
         if (k == 2 || k == 4) begin
            nvec++;
            if ((k == 2 ? i_rdata1 : i_rdata3) !== 32'hDEADBEEF) begin
               nerr++; $display("FAIL write_fetch_data cyc%0d got %h exp deadbeef",
                                k, (k == 2 ? i_rdata1 : i_rdata3));
            end
         end
         commit();
      end
   endtask

   task automatic test_contention();
      logic [5:0] pat;
`ifdef SM_MEM_ARB_RR_EN
      pat = 6'b010101;
`else
      pat = 6'b111111;
`endif
      rst = 1'b1;
      drive(); settle();
      nvec++;
      if (observe() !== exp_v) begin
         nerr++; $display("FAIL contention_rst got %h exp %h", observe(), exp_v);
      end
      commit();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         iq.push_back(32'($urandom_range(15, 0)));
         dq.push_back(mk_d(1'b0, 32'($urandom_range(15, 0)), $urandom));
      end
      for (int k = 0; k < 18; k++) begin
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL contention cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         if (k < 6) begin
            nvec++;
            if ({d_gnt1, i_gnt1} !== {pat[k], ~pat[k]}) begin
               nerr++; $display("FAIL contention_order cyc%0d got d%b i%b exp d%b i%b",
                                k, d_gnt1, i_gnt1, pat[k], ~pat[k]);
            end
         end
         commit();
      end
   endtask

   task automatic test_reset_midflight();
      dq.push_back(mk_d(1'b0, 32'd3, $urandom));
      for (int k = 0; k < 6; k++) begin
         rst = (k == 1);
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL midflight cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         if (k >= 2) begin
            nvec++;
            if ({busy3, i_rvalid3, d_rvalid3, i_rvalid1, d_rvalid1} !== 5'b0) begin
               nerr++; $display("FAIL midflight_quiet cyc%0d got busy %b rv3 %b%b rv1 %b%b exp 0",
                                k, busy3, i_rvalid3, d_rvalid3, i_rvalid1, d_rvalid1);
            end
         end
         commit();
      end
      iq = '{32'd7};
      for (int k = 0; k < 5; k++) begin
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL midflight_fetch cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         if (k == 3) begin
            nvec++;
            if ({i_rvalid3, i_rdata3} !== {1'b1, ref_mem[7]}) begin
               nerr++; $display("FAIL midflight_data got v%b %h exp v1 %h", i_rvalid3, i_rdata3, ref_mem[7]);
            end
         end
         commit();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         rst = ($urandom_range(59, 0) == 0);
         if (iq.size() == 0 && $urandom_range(99, 0) < 60) iq.push_back(32'($urandom_range(15, 0)));
         if (dq.size() == 0 && $urandom_range(99, 0) < 55)
            dq.push_back(mk_d(1'($urandom), 32'($urandom_range(15, 0)), $urandom));
         drive(); settle();
         nvec++;
         if (observe() !== exp_v) begin
            nerr++; $display("FAIL random cyc%0d got %h exp %h", k, observe(), exp_v);
         end
         commit();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      hold_i1 = '0; hold_d1 = '0; hold_i3 = '0; hold_d3 = '0;
      last_d = 1'b0; cyc = 0;
      for (int k = 0; k < 16; k++) begin
         seed_val[k] = $urandom;
         ref_mem[k]  = seed_val[k];
      end
      init_mem = 1'b1;
      @(posedge clk);
      #1;
      init_mem = 1'b0;
      test_reset();
      test_fetch_burst();
      test_priority();
      test_write_then_fetch();
      test_contention();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
